// File: rtl/asi_slv_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asi_slv_ram_pkg
// Description : Shared encodings for the ASI slave RAM model: burst types,
//               response codes and the request arbiter state.
// Revision    : 1.0 - initial release
// ============================================================================
package asi_slv_ram_pkg;

  // AXI burst type encodings
  localparam logic [1:0] BT_FIXED    = 2'b00;
  localparam logic [1:0] BT_INCR     = 2'b01;
  localparam logic [1:0] BT_WRAP     = 2'b10;
  localparam logic [1:0] BT_RESERVED = 2'b11;

  // AXI response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Arbiter: idle, or locked to one user port until its last beat
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WGNT = 2'd1,
    ARB_RGNT = 2'd2
  } arb_state_t;

  // Number of byte-offset bits below the RAM word index
  function automatic int word_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/asi_spram.sv
`default_nettype none
// ============================================================================
// Module      : asi_spram
// Description : Single-port byte-enable RAM with a registered read port and a
//               WS-stage delay line that stretches read latency to WS+1.
//               The RAM array itself is never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module asi_spram #(
  parameter int DW    = 128,
  parameter int DEPTH = 1024,
  parameter int WS    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  input  logic [DW/8-1:0]          be,
  output logic                     rvalid,
  output logic [DW-1:0]            rdata
);

  localparam int C_NB = DW / 8;

  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [WS:0]   r_vld;
  logic [DW-1:0] r_dat [0:WS];
  logic          w_rd;

  assign w_rd = en && !we;

  // Byte-strobed write into the array (no reset: contents survive rst_n)
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < C_NB; i++) begin
        if (be[i]) r_mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Registered read followed by a valid/data shift line; data only moves with
  // a valid so the last stage holds its value between beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k <= WS; k++) r_dat[k] <= '0;
    end else begin
      r_vld[0] <= w_rd;
      if (w_rd) r_dat[0] <= r_mem[addr];
      for (int k = 1; k <= WS; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) r_dat[k] <= r_dat[k-1];
      end
    end
  end

  assign rvalid = r_vld[WS];
  assign rdata  = r_dat[WS];

endmodule
`default_nettype wire

// File: rtl/asi_slv_ram.sv
`default_nettype none
// ============================================================================
// Module      : asi_slv_ram
// Description : ASI default slave. Arbitrates the write and read user ports
//               with burst locking and serves beats from a byte-strobed RAM,
//               returning read data SLV_WS+1 cycles after each read beat.
// Revision    : 1.0 - initial release
// ============================================================================
module asi_slv_ram
  import asi_slv_ram_pkg::*;
#(
  parameter int AXI_DW      = 128,
  parameter int AXI_AW      = 32,
  parameter int AXI_SW      = 3,
  parameter int ASI_ARB     = 0,
  parameter int SLV_WS      = 1,
  parameter int SLV_MAXSIZE = 4,
  parameter int MEM_DEPTH   = 1024
) (
  input  logic                usr_clk,
  input  logic                usr_reset_n,
  input  logic                usr_wrequest,
  output logic                usr_wgrant,
  input  logic [AXI_AW-1:0]   usr_waddr,
  input  logic [AXI_SW-1:0]   usr_wsize,
  input  logic [AXI_DW-1:0]   usr_wdata,
  input  logic [AXI_DW/8-1:0] usr_wstrb,
  input  logic                usr_wlast,
  input  logic                usr_we,
  output logic                usr_wsize_error,
  input  logic                usr_rrequest,
  output logic                usr_rgrant,
  input  logic [AXI_AW-1:0]   usr_raddr,
  input  logic                usr_re,
  input  logic                usr_rlast,
  output logic [AXI_DW-1:0]   usr_rdata,
  output logic                usr_rvalid
);

  localparam int C_OFF = word_lsb(AXI_DW);
  localparam int C_IW  = $clog2(MEM_DEPTH);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_wr_beat;
  logic              w_rd_beat;
  logic [C_IW-1:0]   w_addr;
  logic              w_unused_ok;

  // Arbiter state register
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) r_state <= ARB_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Next-state: grant from idle, release only on the granted port's last beat
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (usr_wrequest && usr_rrequest)
          w_state_nxt = (ASI_ARB != 0) ? ARB_RGNT : ARB_WGNT;
        else if (usr_wrequest)
          w_state_nxt = ARB_WGNT;
        else if (usr_rrequest)
          w_state_nxt = ARB_RGNT;
      end
      ARB_WGNT: if (usr_we && usr_wlast) w_state_nxt = ARB_IDLE;
      ARB_RGNT: if (usr_re && usr_rlast) w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  // Grants decode straight from the state register, so they are glitch-free
  assign usr_wgrant = (r_state == ARB_WGNT);
  assign usr_rgrant = (r_state == ARB_RGNT);

  assign w_wr_beat = usr_we && usr_wgrant;
  assign w_rd_beat = usr_re && usr_rgrant;

  // Word index truncates to the RAM depth; upper address bits wrap silently
  assign w_addr = usr_wgrant ? usr_waddr[C_OFF +: C_IW] : usr_raddr[C_OFF +: C_IW];

  // Oversized beats are only flagged; their strobed bytes are still written
  assign usr_wsize_error = (usr_wsize > AXI_SW'(SLV_MAXSIZE));

  // Byte offsets and wrapped-away address bits carry no meaning here
  assign w_unused_ok = &{1'b0, usr_waddr, usr_raddr};

  asi_spram #(
    .DW    (AXI_DW),
    .DEPTH (MEM_DEPTH),
    .WS    (SLV_WS)
  ) u_spram (
    .clk    (usr_clk),
    .rst_n  (usr_reset_n),
    .en     (w_wr_beat || w_rd_beat),
    .we     (w_wr_beat),
    .addr   (w_addr),
    .wdata  (usr_wdata),
    .be     (usr_wstrb),
    .rvalid (usr_rvalid),
    .rdata  (usr_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_asi_slv_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_asi_slv_ram
// Description : Randomized self-checking bench for asi_slv_ram with a
//               byte-array memory model and an expected-read queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asi_slv_ram;

  localparam int DW = 128, AW = 32, SW = 3, WS = 3, MAXS = 4, DEPTH = 64, NB = DW / 8;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance (write wins, 3 wait states)
  logic          wreq = 0, wg, wlast = 0, we = 0, werr;
  logic [AW-1:0] waddr = '0, raddr = '0;
  logic [SW-1:0] wsize = '0;
  logic [DW-1:0] wdata = '0, rdata;
  logic [NB-1:0] wstrb = '0;
  logic          rreq = 0, rg, re = 0, rlast = 0, rvalid;

  // second instance (read wins)
  logic          wreq_b = 0, wg_b, wlast_b = 0, we_b = 0, werr_b;
  logic          rreq_b = 0, rg_b, re_b = 0, rlast_b = 0, rvalid_b;
  logic [DW-1:0] rdata_b;

  asi_slv_ram #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(SW), .ASI_ARB(0), .SLV_WS(WS),
                .SLV_MAXSIZE(MAXS), .MEM_DEPTH(DEPTH)) dut (
    .usr_clk(clk), .usr_reset_n(rst_n),
    .usr_wrequest(wreq), .usr_wgrant(wg), .usr_waddr(waddr), .usr_wsize(wsize),
    .usr_wdata(wdata), .usr_wstrb(wstrb), .usr_wlast(wlast), .usr_we(we),
    .usr_wsize_error(werr), .usr_rrequest(rreq), .usr_rgrant(rg), .usr_raddr(raddr),
    .usr_re(re), .usr_rlast(rlast), .usr_rdata(rdata), .usr_rvalid(rvalid));

  asi_slv_ram #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(SW), .ASI_ARB(1), .SLV_WS(1),
                .SLV_MAXSIZE(MAXS), .MEM_DEPTH(DEPTH)) dut_b (
    .usr_clk(clk), .usr_reset_n(rst_n),
    .usr_wrequest(wreq_b), .usr_wgrant(wg_b), .usr_waddr('0), .usr_wsize('0),
    .usr_wdata('0), .usr_wstrb('0), .usr_wlast(wlast_b), .usr_we(we_b),
    .usr_wsize_error(werr_b), .usr_rrequest(rreq_b), .usr_rgrant(rg_b), .usr_raddr('0),
    .usr_re(re_b), .usr_rlast(rlast_b), .usr_rdata(rdata_b), .usr_rvalid(rvalid_b));

  int            n_chk = 0, n_fail = 0, cyc = 0;
  logic [DW-1:0] mem_m [0:DEPTH-1];
  exp_t          eq[$];
  logic [DW-1:0] obs_q[$];
  logic [DW-1:0] last_rd = '0;
  logic [DW-1:0] bd_q[$];
  logic [NB-1:0] bs_q[$];
  bit            gaps_en = 1;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a / NB) % DEPTH);
  endfunction

  // cycle counter: value k after the k-th rising edge
  always @(posedge clk) cyc++;

  // compare process: grants one-hot, read returns exactly when due, data held otherwise
  always @(negedge clk) begin
    if (!rst_n) begin
      last_rd = '0;
      check("reset_outputs", {wg, rg, rvalid, (rdata != '0)}, '0);
    end else begin
      check("grant_onehot", DW'(wg && rg), '0);
      if (eq.size() > 0 && eq[0].due <= cyc) begin
        check("rvalid_due", DW'(rvalid), 1);
        check("rdata", rdata, eq[0].d);
        obs_q.push_back(rdata);
        last_rd = eq[0].d;
        void'(eq.pop_front());
      end else begin
        check("rvalid_idle", DW'(rvalid), 0);
        check("rdata_hold", rdata, last_rd);
      end
    end
  end

  task automatic gap();
    if (gaps_en) while ($urandom_range(3) == 0) begin @(posedge clk); #1; end
  endtask

  // write burst of the queued beats; exp_lat < 0 skips the grant-latency check
  task automatic wr_burst(input logic [AW-1:0] addr, input int exp_lat);
    int lat = 0;
    wreq = 1;
    do begin @(posedge clk); #1; lat++; end while (!wg && lat < 50);
    wreq = 0;   // request drops while granted; grant must hold
    if (!wg) begin
      check("wgrant_timeout", 0, 1);
      bd_q.delete(); bs_q.delete();
      return;
    end
    if (exp_lat >= 0) check("wgrant_latency", DW'(lat), DW'(exp_lat));
    for (int i = 0; i < bd_q.size(); i++) begin
      we = 0;
      gap();
      check("wgrant_held", DW'(wg), 1);
      we = 1; waddr = addr + AW'(i * NB); wdata = bd_q[i]; wstrb = bs_q[i];
      wlast = (i == bd_q.size() - 1); wsize = SW'($urandom_range(7));
      for (int b = 0; b < NB; b++)
        if (wstrb[b]) mem_m[widx(waddr)][b*8 +: 8] = wdata[b*8 +: 8];
      @(posedge clk); #1;
    end
    we = 0; wlast = 0;
    check("wgrant_release", DW'(wg), 0);
    bd_q.delete(); bs_q.delete();
  endtask

  task automatic rd_burst(input logic [AW-1:0] addr, input int n, input int exp_lat);
    int lat = 0;
    rreq = 1;
    do begin @(posedge clk); #1; lat++; end while (!rg && lat < 50);
    rreq = 0;
    if (!rg) begin check("rgrant_timeout", 0, 1); return; end
    if (exp_lat >= 0) check("rgrant_latency", DW'(lat), DW'(exp_lat));
    for (int i = 0; i < n; i++) begin
      re = 0;
      gap();
      check("rgrant_held", DW'(rg), 1);
      re = 1; raddr = addr + AW'(i * NB); rlast = (i == n - 1);
      eq.push_back('{cyc + WS + 1, mem_m[widx(raddr)]});
      @(posedge clk); #1;
    end
    re = 0; rlast = 0;
    check("rgrant_release", DW'(rg), 0);
  endtask

  task automatic drain();
    int t = 0;
    while (eq.size() > 0 && t < 50) begin @(posedge clk); #1; t++; end
    if (eq.size() > 0) begin check("drain_timeout", 0, 1); eq.delete(); end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [DW-1:0] v;
    int lat;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_wgrant", DW'(wg), 0);
    check("reset_rdata", rdata, '0);
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_grants", DW'({wg, rg, wg_b, rg_b}), 0);
    end

    // size error flag is combinational
    for (int s = 0; s < 8; s++) begin
      wsize = SW'(s); #1;
      check("wsize_error", DW'(werr), DW'(s > MAXS));
    end
    @(posedge clk); #1;

    // fill the whole RAM so every later read has known contents
    for (int i = 0; i < DEPTH; i++) begin
      bd_q.push_back({$urandom, $urandom, $urandom, $urandom}); bs_q.push_back('1);
    end
    wr_burst(0, 1);

    // 4-beat INCR at 0x100, readback
    for (int i = 0; i < 4; i++) begin bd_q.push_back(DW'(8'hA0 + i)); bs_q.push_back('1); end
    wr_burst(32'h100, 1);
    obs_q.delete();
    rd_burst(32'h100, 4, 1);
    drain();
    for (int i = 0; i < 4; i++)
      check("incr_readback", (obs_q.size() > i) ? obs_q[i] : 'x, DW'(8'hA0 + i));

    // partial strobe
    bd_q.push_back('1); bs_q.push_back('1);
    wr_burst(32'h200, 1);
    bd_q.push_back('0); bs_q.push_back(NB'(16'h000F));
    wr_burst(32'h200, 1);
    obs_q.delete();
    rd_burst(32'h200, 1, 1);
    drain();
    check("partial_strobe", (obs_q.size() > 0) ? obs_q[0] : 'x, {{(DW-32){1'b1}}, 32'h0});

    // address wrap
    v = {$urandom, $urandom, $urandom, $urandom};
    bd_q.push_back(v); bs_q.push_back('1);
    wr_burst(AW'((DEPTH + 5) * NB), 1);
    obs_q.delete();
    rd_burst(AW'(5 * NB), 1, 1);
    drain();
    check("addr_wrap", (obs_q.size() > 0) ? obs_q[0] : 'x, v);

    // beats without a grant are ignored
    we = 1; wlast = 1; waddr = 0; wstrb = '1; wdata = ~mem_m[0];
    re = 1; rlast = 1; raddr = 0;
    repeat (2) @(posedge clk);
    #1;
    we = 0; wlast = 0; re = 0; rlast = 0;
    rd_burst(0, 1, 1);
    drain();

    // simultaneous requests, write wins: write 2 beats, read granted after 1 idle
    gaps_en = 0;
    bd_q.push_back(DW'(32'h1234)); bs_q.push_back('1);
    bd_q.push_back(DW'(32'h5678)); bs_q.push_back('1);
    fork
      wr_burst(AW'(40 * NB), 1);
      rd_burst(AW'(10 * NB), 2, 4);
    join
    drain();
    gaps_en = 1;

    // read-wins instance: read first, then write after one idle cycle
    wreq_b = 1; rreq_b = 1;
    @(posedge clk); #1;
    check("arb1_first", DW'({wg_b, rg_b}), DW'(2'b01));
    wreq_b = 1; rreq_b = 0; re_b = 1; rlast_b = 1;
    @(posedge clk); #1;
    re_b = 0; rlast_b = 0;
    check("arb1_idle", DW'({wg_b, rg_b}), DW'(2'b00));
    @(posedge clk); #1;
    check("arb1_second", DW'({wg_b, rg_b}), DW'(2'b10));
    wreq_b = 0; we_b = 1; wlast_b = 1;
    @(posedge clk); #1;
    we_b = 0; wlast_b = 0;
    check("arb1_release", DW'({wg_b, rg_b}), DW'(2'b00));

    // randomized bursts
    for (int t = 0; t < 30; t++) begin
      int n = $urandom_range(1, 8);
      logic [AW-1:0] a = $urandom;
      if ($urandom_range(1) == 0) begin
        for (int i = 0; i < n; i++) begin
          bd_q.push_back({$urandom, $urandom, $urandom, $urandom});
          bs_q.push_back(NB'($urandom));
        end
        wr_burst(a, 1);
      end else begin
        rd_burst(a, n, 1);
      end
    end
    drain();

    // reset during an 8-beat read: only 5 beats issued before reset
    rreq = 1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!rg && lat < 50);
    rreq = 0;
    check("mid_rgrant", DW'(rg), 1);
    for (int i = 0; i < 5; i++) begin
      re = 1; raddr = AW'(i * NB); rlast = 0;
      eq.push_back('{cyc + WS + 1, mem_m[i]});
      @(posedge clk); #1;
    end
    re = 0;
    rst_n = 0;
    eq.delete();
    #1;
    check("mid_reset_out", DW'({rg, rvalid}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    obs_q.delete();
    rd_burst(0, 1, 1);
    drain();
    check("post_reset_ram", (obs_q.size() > 0) ? obs_q[0] : 'x, mem_m[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
